// File: rtl/button_debouncer.sv
// button_debouncer
//   Turns one raw, bouncing push-button pad into a clean level for the
//   downstream single-pulse edge detector. It also raises a long-press flag
//   once the clean level has been high for HOLD_CYCLES clocks.
//
// Parameters
//   STABLE_CYCLES  consecutive synchronised samples needed to accept a change (>= 2)
//   HOLD_CYCLES    cycles after btn_clean rises before held asserts (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_raw    in   raw pad level (asynchronous, may bounce)
//   btn_clean  out  debounced level, registered
//   held       out  long-press flag, registered
//
// State table
//   state        | meaning
//   IDLE         | clean level low, waiting for sync2 to go high
//   PRESS_WAIT   | sync2 high, counting stable samples before accepting press
//   PRESSED      | clean level high, hold counter running
//   RELEASE_WAIT | sync2 low, counting stable samples before accepting release

module button_debouncer #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES   = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_clean,
  output logic held
);

  localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] hold_inc;
  logic             btn_clean_q, btn_clean_d;
  logic             held_q, held_d;

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_cnt_d = hold_cnt_q;

    // hold counter saturates rather than wrapping
    hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + CNT_ONE;

    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (cnt_q == STABLE_LAST) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        hold_cnt_d = hold_inc;
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // a short release bounce must not delay the long-press flag,
        // so the hold counter keeps running here
        hold_cnt_d = hold_inc;
        if (sync2_q) begin
          state_d = PRESSED;
        end else if (cnt_q == STABLE_LAST) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        hold_cnt_d = '0;
      end
    endcase

    // outputs are decoded from the next state so they are registered
    // and change on the same edge as the state
    btn_clean_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    held_d      = btn_clean_d && (hold_cnt_d == HOLD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_cnt_q  <= '0;
      btn_clean_q <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      btn_clean_q <= btn_clean_d;
      held_q      <= held_d;
    end
  end

  assign btn_clean = btn_clean_q;
  assign held      = held_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer
//   Directed bench for button_debouncer with STABLE_CYCLES = 4, HOLD_CYCLES = 20.
//   Stimulus pushes expected output changes ({btn_clean, held} and the cycle
//   they must appear on) into a queue; a monitor pops one entry each time the
//   outputs change and compares.

module tb_button_debouncer;

  localparam int STABLE = 4;
  localparam int HOLD   = 20;
  localparam int LAT    = STABLE + 3;

  logic clk;
  logic rst_n;
  logic btn_raw;
  logic btn_clean;
  logic held;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] val;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  button_debouncer #(
    .STABLE_CYCLES(STABLE),
    .HOLD_CYCLES  (HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_clean(btn_clean),
    .held     (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic push_exp(input int c, input logic [1:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.val = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_out(input string name, input logic [1:0] exp_v);
    checks++;
    if ({btn_clean, held} !== exp_v) begin
      errors++;
      $display("FAIL %s: {btn_clean,held} actual=%b required=%b at cycle %0d",
               name, {btn_clean, held}, exp_v, cyc);
    end
  endtask

  // monitor: every output change must match the next queued expectation
  logic [1:0] prev_out = 2'b00;
  always @(negedge clk) begin
    logic [1:0] cur;
    exp_t e;
    cur = {btn_clean, held};
    if (cur !== prev_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: {btn_clean,held} actual=%b (was %b) required=no change at cycle %0d",
                 cur, prev_out, cyc);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s: actual=%b at cycle %0d required=%b at cycle %0d",
                   e.tag, cur, cyc, e.val, e.cyc);
        end
      end
      prev_out = cur;
    end
  end

  initial begin
    int t0;
    btn_raw = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_out("reset_state", 2'b00);
    step(3);
    rst_n = 1'b1;
    step(3);

    // clean press, long hold, release
    t0 = cyc;
    btn_raw = 1'b1;
    push_exp(t0 + LAT, 2'b10, "clean_press_rise");
    push_exp(t0 + LAT + HOLD, 2'b11, "clean_press_held");
    step(LAT - 1);
    check_out("press_not_early", 2'b00);
    step(1);
    check_out("press_rise_level", 2'b10);
    step(40 - LAT);
    check_out("held_after_40", 2'b11);
    t0 = cyc;
    btn_raw = 1'b0;
    push_exp(t0 + LAT, 2'b00, "release_both_fall");
    step(LAT - 1);
    check_out("release_not_early", 2'b11);
    step(1);
    check_out("release_fall_level", 2'b00);
    step(10);

    // press bounce: 1,1,1,0 x5, then steady 1
    for (int r = 0; r < 5; r++) begin
      btn_raw = 1'b1;
      step(3);
      btn_raw = 1'b0;
      step(1);
    end
    check_out("press_bounce_rejected", 2'b00);
    t0 = cyc;
    btn_raw = 1'b1;
    push_exp(t0 + LAT, 2'b10, "bounce_then_press_rise");
    step(LAT + 2);

    // release bounce: low 3 cycles then high keeps the level
    btn_raw = 1'b0;
    step(3);
    btn_raw = 1'b1;
    step(3);
    check_out("release_bounce_kept", 2'b10);
    t0 = cyc;
    btn_raw = 1'b0;
    push_exp(t0 + LAT, 2'b00, "release_after_bounce_fall");
    step(LAT + 5);

    // long hold with a release bounce in the middle: held not delayed
    t0 = cyc;
    btn_raw = 1'b1;
    push_exp(t0 + LAT, 2'b10, "hold_bounce_rise");
    push_exp(t0 + LAT + HOLD, 2'b11, "hold_bounce_held");
    step(LAT + 5);
    btn_raw = 1'b0;
    step(3);
    btn_raw = 1'b1;
    step(LAT + HOLD - 1 - (LAT + 8));
    check_out("held_not_early", 2'b10);
    step(1);
    check_out("held_on_time", 2'b11);
    step(5);
    t0 = cyc;
    btn_raw = 1'b0;
    push_exp(t0 + LAT, 2'b00, "hold_release_fall");
    step(LAT + 5);

    // short press: 3-cycle pulse ignored
    btn_raw = 1'b1;
    step(3);
    btn_raw = 1'b0;
    step(12);
    check_out("short_press_ignored", 2'b00);

    // reset during PRESS_WAIT, release reset with button still down
    btn_raw = 1'b1;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("reset_in_press_wait", 2'b00);
    step(2);
    rst_n = 1'b1;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b10, "post_reset_press_rise");
    step(LAT - 1);
    check_out("post_reset_not_early", 2'b00);
    step(4);
    t0 = cyc;
    btn_raw = 1'b0;
    push_exp(t0 + LAT, 2'b00, "post_reset_release_fall");
    step(LAT + 5);

    // asynchronous reset with both outputs high clears them without a clock
    t0 = cyc;
    btn_raw = 1'b1;
    push_exp(t0 + LAT, 2'b10, "pre_reset_rise");
    push_exp(t0 + LAT + HOLD, 2'b11, "pre_reset_held");
    step(LAT + HOLD + 3);
    push_exp(cyc + 1, 2'b00, "async_reset_fall");
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset_clears", 2'b00);
    step(1);
    btn_raw = 1'b0;
    rst_n   = 1'b1;
    step(10);
    check_out("idle_after_reset", 2'b00);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: pending expected changes actual=%0d required=0 (next: %s)",
               exp_q.size(), exp_q[0].tag);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions one raw push-button input from the Basys 3 board into a clean, glitch-free level for the single-pulse edge-detector FSM that sits directly downstream. The block synchronises the asynchronous pad signal, then requires it to hold steady for a programmable number of clock cycles before the clean level changes. It also flags a long press, which the time-setting logic uses for fast adjustment. There is one instance per board button.

## Interface
- STABLE_CYCLES, default 1_000_000: consecutive synchronised samples needed to accept a level change (10 ms at 100 MHz). Must be ≥ 2.
- HOLD_CYCLES, default 100_000_000: cycles after `btn_clean` rises before `held` asserts (1 s). Must be ≥ 1.
- CNT_W: derived localparam. Width = $clog2(max(STABLE_CYCLES, HOLD_CYCLES) + 1). It is not user-set.
- `clk`  in  1  system clock, 100 MHz. All logic uses the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_raw`  in  1  raw pad signal. It is asynchronous and may bounce.
- `btn_clean`  out  1  debounced level, registered. It drives the downstream FSM `w` input.
- `held`  out  1  long-press flag, registered.

## Operation
- **Reset.** While `rst_n` = 0:
  - the synchroniser FFs `sync1`/`sync2`, the state, the debounce counter and the hold counter are all 0;
  - the state is IDLE;
  - `btn_clean` = 0 and `held` = 0 immediately, with no clock needed.
- **Synchroniser.** Two-flop: `sync1` <= `btn_raw`, then `sync2` <= `sync1`. The FSM only reads `sync2`.
- **FSM states.** The state register holds 4 states; `btn_clean` is 1 in PRESSED and RELEASE_WAIT only.
  - IDLE: if `sync2` = 1, go to PRESS_WAIT with `cnt` = 0.
  - PRESS_WAIT:
    - if `sync2` = 0, return to IDLE (bounce rejected);
    - else if `cnt` = STABLE_CYCLES−1, go to PRESSED with `hold_cnt` = 0;
    - else `cnt`++.
  - PRESSED:
    - if `sync2` = 0, go to RELEASE_WAIT with `cnt` = 0;
    - `hold_cnt` increments every cycle, saturating at HOLD_CYCLES.
  - RELEASE_WAIT:
    - if `sync2` = 1, return to PRESSED; `hold_cnt` is not cleared;
    - else if `cnt` = STABLE_CYCLES−1, go to IDLE, clearing `hold_cnt`;
    - else `cnt`++;
    - `hold_cnt` keeps incrementing and saturating in this state.
- **`held`.** `held` = 1 when `hold_cnt` = HOLD_CYCLES, and 0 otherwise. It clears on the same edge that `btn_clean` falls.
- **Counter overflow.** Counters never wrap. `cnt` is bounded by the state transitions; `hold_cnt` saturates.
- **Encoding.** Illegal or unused state encodings go to IDLE on the next edge.

## Timing
- **Press latency.** Let edge 1 be the first rising edge that samples `btn_raw` = 1, with the input stable thereafter.
  - `sync2` = 1 after edge 2.
  - PRESS_WAIT with `cnt` = 0 after edge 3.
  - `btn_clean` = 1 after edge STABLE_CYCLES+3.
- **Release latency.** Symmetric: `btn_clean` = 0 after edge STABLE_CYCLES+3, counting from the first edge that samples 0.
- **Bounce rejection.** Any opposite-level sample in `sync2` during a WAIT state aborts the change. The next qualifying run restarts the count from 0.
- **`held` timing.** `held` rises exactly HOLD_CYCLES edges after the edge on which `btn_clean` rose. Release bounces shorter than STABLE_CYCLES do not delay it.
- **Output glitches.** `btn_clean` changes at most once per qualifying run. It never pulses for a single cycle on its own, so the downstream FSM sees exactly one rising edge per accepted press.
- **Reset mid-operation.** Asserting `rst_n` at any point forces both outputs low asynchronously. After release, the block restarts from IDLE. If `btn_raw` is 1 at that moment, it is treated as a new press with full latency.

## Test plan
Benches use STABLE_CYCLES = 4 and HOLD_CYCLES = 20.

1. **Clean press.** `btn_raw` 0→1 and held for 40 cycles → `btn_clean` = 1 after edge 7 exactly. No earlier change, and it stays 1.
2. **Press bounce.** `btn_raw` pattern 1,1,1,0 repeated 5 times, then steady 1 → `btn_clean` stays 0 throughout the pattern, then rises 7 edges after the final 0→1.
3. **Release bounce.** While PRESSED, `btn_raw` low for 3 cycles then high → `btn_clean` stays 1. A later steady low gives `btn_clean` = 0 after edge 7.
4. **Long hold.**
   - Keep `btn_raw` high → `held` = 1 exactly 20 edges after `btn_clean` rose.
   - Then release → `held` and `btn_clean` fall on the same edge, 7 edges after release.
5. **Short press.** A 3-cycle high pulse on `btn_raw` → `btn_clean` and `held` remain 0.
6. **Reset during PRESS_WAIT.**
   - Pull `rst_n` low mid-count → outputs 0 immediately, with no clean rising edge.
   - Release `rst_n` with `btn_raw` = 1 → `btn_clean` rises 7 edges later.
